sseg_scan_decoder: RTL

- Receive-side counterpart of the time-multiplexed 7-segment driver (disp_mux + hex_to_sseg).
- Watches the scanned an/sseg bus and rebuilds the four raw digit patterns. Decodes each pattern back to a hex nibble plus decimal point.
- Pulses once per complete frame.
- Used for on-board loopback checks and by benches that check fp_adder results without decoding segments by hand.

---
 rtl/sseg_scan_decoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_decoder.sv
// Rebuilds the four digit patterns from a scanned an/sseg bus and decodes them to hex.
// Optional SSEG_SCAN_SYNC_EN adds a 2-flop input synchroniser for asynchronous sources.
module sseg_scan_decoder #(
  parameter int unsigned AN_ACTIVE_LOW  = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned SETTLE         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [7:0] dig0,
  output logic [7:0] dig1,
  output logic [7:0] dig2,
  output logic [7:0] dig3,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic [3:0] hex2,
  output logic [3:0] hex3,
  output logic [3:0] hex_ok,
  output logic [3:0] dp,
  output logic       frame_tick,
  output logic       an_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CAP_AT   = CNT_W'(SETTLE - 1);
  localparam logic [3:0] AN_IDLE  = (AN_ACTIVE_LOW != 0)  ? 4'hF  : 4'h0;
  localparam logic [7:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {ST_BLANK, ST_DWELL, ST_ILLEGAL} scan_state_e;

  logic [3:0]       w_an_raw;
  logic [7:0]       w_seg_raw;
  logic [3:0]       w_an;
  logic [7:0]       w_seg;
  scan_state_e      w_state;
  logic [1:0]       w_idx;
  logic             w_changed;
  logic             w_capture;
  logic [4:0]       w_dec;

  logic [3:0]       r_prev_an;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [3:0]       r_seen;
  logic [7:0]       r_dig [4];
  logic [3:0]       r_hex [4];
  logic [3:0]       r_hex_ok;
  logic [3:0]       r_dp;
  logic             r_frame_tick;
  logic             r_an_err;

`ifdef SSEG_SCAN_SYNC_EN
  logic [3:0] r_an_s1, r_an_s2;
  logic [7:0] r_seg_s1, r_seg_s2;

  // Two-stage synchroniser, parked at the inactive bus levels in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_s1  <= AN_IDLE;
      r_an_s2  <= AN_IDLE;
      r_seg_s1 <= SEG_IDLE;
      r_seg_s2 <= SEG_IDLE;
    end else begin
      r_an_s1  <= an;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= sseg;
      r_seg_s2 <= r_seg_s1;
    end
  end

  assign w_an_raw  = r_an_s2;
  assign w_seg_raw = r_seg_s2;
`else
  logic [3:0] w_an_idle_unused;
  logic [7:0] w_seg_idle_unused;
  assign w_an_idle_unused  = AN_IDLE;
  assign w_seg_idle_unused = SEG_IDLE;
  assign w_an_raw  = an;
  assign w_seg_raw = sseg;
`endif

  assign w_an  = (AN_ACTIVE_LOW != 0)  ? ~w_an_raw  : w_an_raw;
  assign w_seg = (SEG_ACTIVE_LOW != 0) ? ~w_seg_raw : w_seg_raw;

  // Segment glyph to {legal, nibble}
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h00;
    case (p)
      7'h7E: r = 5'h10;  7'h30: r = 5'h11;  7'h6D: r = 5'h12;  7'h79: r = 5'h13;
      7'h33: r = 5'h14;  7'h5B: r = 5'h15;  7'h5F: r = 5'h16;  7'h70: r = 5'h17;
      7'h7F: r = 5'h18;  7'h7B: r = 5'h19;  7'h77: r = 5'h1A;  7'h1F: r = 5'h1B;
      7'h4E: r = 5'h1C;  7'h3D: r = 5'h1D;  7'h4F: r = 5'h1E;  7'h47: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Classify the anode code and locate the selected digit
  always_comb begin
    w_state = ST_BLANK;
    w_idx   = 2'd0;
    case (w_an)
      4'b0000: w_state = ST_BLANK;
      4'b0001: begin w_state = ST_DWELL; w_idx = 2'd0; end
      4'b0010: begin w_state = ST_DWELL; w_idx = 2'd1; end
      4'b0100: begin w_state = ST_DWELL; w_idx = 2'd2; end
      4'b1000: begin w_state = ST_DWELL; w_idx = 2'd3; end
      default: w_state = ST_ILLEGAL;
    endcase
  end

  // An anode change on the capture edge restarts the dwell instead of capturing
  assign w_changed = (w_an != r_prev_an);
  assign w_capture = (w_state == ST_DWELL) && !w_changed && (r_cnt == CAP_AT) && !r_done;
  assign w_dec     = seg_decode(w_seg[6:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_an    <= 4'h0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_seen       <= 4'h0;
      r_hex_ok     <= 4'h0;
      r_dp         <= 4'h0;
      r_frame_tick <= 1'b0;
      r_an_err     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_dig[i] <= 8'h00;
        r_hex[i] <= 4'h0;
      end
    end else begin
      r_prev_an    <= w_an;
      r_frame_tick <= 1'b0;
      r_an_err     <= (w_state == ST_ILLEGAL) && w_changed;
      if (w_changed) begin
        r_cnt  <= '0;
        r_done <= 1'b0;
      end else if (r_cnt != SETTLE_C) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_dig[w_idx]    <= w_seg;
        r_hex[w_idx]    <= w_dec[3:0];
        r_hex_ok[w_idx] <= w_dec[4];
        r_dp[w_idx]     <= w_seg[7];
        r_done          <= 1'b1;
        if ((r_seen | w_an) == 4'hF) begin
          r_seen       <= 4'h0;
          r_frame_tick <= 1'b1;
        end else begin
          r_seen <= r_seen | w_an;
        end
      end
    end
  end

  assign dig0       = r_dig[0];
  assign dig1       = r_dig[1];
  assign dig2       = r_dig[2];
  assign dig3       = r_dig[3];
  assign hex0       = r_hex[0];
  assign hex1       = r_hex[1];
  assign hex2       = r_hex[2];
  assign hex3       = r_hex[3];
  assign hex_ok     = r_hex_ok;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;
  assign an_err     = r_an_err;

endmodule
